// File: rtl/phy_tx_scheduler_pkg.sv
// Shared PHY transmit types: encoder symbol selects and the TX scheduler state encoding.
package phy_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        NADA_SEL         = 3'd0,
        START_PACKET_SEL = 3'd1,
        END_PACKET_SEL   = 3'd2,
        DATA_SEL         = 3'd3,
        ACK_SEL          = 3'd4,
        GRTCRED0_SEL     = 3'd5,
        GRTCRED1_SEL     = 3'd6
    } comma_sel_t;

    typedef enum logic [1:0] {
        NADA                = 2'd0,
        SELECT_COMMA_1_FLIT = 2'd1,
        SELECT_COMMA_2_FLIT = 2'd2,
        SELECT_COMMA_DATA   = 2'd3
    } comma_length_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CTRL  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_END   = 3'd4
    } tx_sched_state_t;

endpackage

// File: rtl/phy_tx_token_cnt.sv
// Saturating up/down counter of pending control tokens with a sticky overflow flag.
module phy_tx_token_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == '1) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/phy_tx_scheduler.sv
// PHY TX scheduler: picks the next encoder symbol among pending control tokens and the
// packet stream (START, pass-through DATA, END), with a starvation guard for packets.
module phy_tx_scheduler
    import phy_tx_scheduler_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 4,
    parameter int MAX_CTRL_BURST = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] pkt_data,
    input  logic              pkt_last,
    output logic              pkt_ready,
    input  logic              ack_req,
    input  logic [1:0]        grtcred_req,
    output logic              enc_valid,
    input  logic              enc_ready,
    output comma_sel_t        enc_comma_sel,
    output comma_length_sel_t enc_comma_len,
    output logic [DATA_W-1:0] enc_data,
    output logic              ovf_err
);

    localparam int BURST_W = $clog2(MAX_CTRL_BURST + 1);

    tx_sched_state_t    state;
    comma_sel_t         tok_sel;
    logic [BURST_W-1:0] burst;
    logic               burst_full;

    logic [CNT_W-1:0]   ack_cnt, grt0_cnt, grt1_cnt;
    logic               ack_ovf, grt0_ovf, grt1_ovf;
    logic               tok_hs;

    assign burst_full = (burst == BURST_W'(MAX_CTRL_BURST));
    assign tok_hs     = (state == ST_CTRL) && enc_ready;
    assign ovf_err    = ack_ovf | grt0_ovf | grt1_ovf;

    phy_tx_token_cnt #(.CNT_W(CNT_W)) u_ack_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (ack_req),
        .dec   (tok_hs && tok_sel == ACK_SEL),
        .count (ack_cnt),
        .ovf   (ack_ovf)
    );

    phy_tx_token_cnt #(.CNT_W(CNT_W)) u_grt0_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (grtcred_req[0]),
        .dec   (tok_hs && tok_sel == GRTCRED0_SEL),
        .count (grt0_cnt),
        .ovf   (grt0_ovf)
    );

    phy_tx_token_cnt #(.CNT_W(CNT_W)) u_grt1_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (grtcred_req[1]),
        .dec   (tok_hs && tok_sel == GRTCRED1_SEL),
        .count (grt1_cnt),
        .ovf   (grt1_ovf)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            tok_sel <= NADA_SEL;
            burst   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!pkt_valid) begin
                        burst <= '0;
                    end
                    // A waiting packet wins once it has watched MAX_CTRL_BURST tokens go by.
                    if (pkt_valid && burst_full) begin
                        state <= ST_START;
                    end else if (ack_cnt != '0) begin
                        state   <= ST_CTRL;
                        tok_sel <= ACK_SEL;
                    end else if (grt0_cnt != '0) begin
                        state   <= ST_CTRL;
                        tok_sel <= GRTCRED0_SEL;
                    end else if (grt1_cnt != '0) begin
                        state   <= ST_CTRL;
                        tok_sel <= GRTCRED1_SEL;
                    end else if (pkt_valid) begin
                        state <= ST_START;
                    end
                end
                ST_CTRL: begin
                    if (enc_ready) begin
                        state <= ST_IDLE;
                        if (pkt_valid && !burst_full) begin
                            burst <= burst + BURST_W'(1);
                        end
                    end
                end
                ST_START: begin
                    if (enc_ready) begin
                        state <= ST_DATA;
                        burst <= '0;
                    end
                end
                ST_DATA: begin
                    if (pkt_valid && enc_ready && pkt_last) begin
                        state <= ST_END;
                    end
                end
                ST_END: begin
                    if (enc_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output takes a default before the case so no path infers a latch.
        enc_valid     = 1'b0;
        pkt_ready     = 1'b0;
        enc_comma_sel = NADA_SEL;
        enc_comma_len = NADA;
        enc_data      = '0;
        case (state)
            ST_CTRL: begin
                enc_valid     = 1'b1;
                enc_comma_sel = tok_sel;
                enc_comma_len = SELECT_COMMA_1_FLIT;
            end
            ST_START: begin
                enc_valid     = 1'b1;
                enc_comma_sel = START_PACKET_SEL;
                enc_comma_len = SELECT_COMMA_1_FLIT;
            end
            ST_DATA: begin
                enc_valid     = pkt_valid;
                pkt_ready     = enc_ready;
                enc_data      = pkt_data;
                enc_comma_sel = DATA_SEL;
                enc_comma_len = SELECT_COMMA_DATA;
            end
            ST_END: begin
                enc_valid     = 1'b1;
                enc_comma_sel = END_PACKET_SEL;
                enc_comma_len = SELECT_COMMA_1_FLIT;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Self-checking bench for phy_tx_scheduler: scoreboard of expected encoder symbols plus
// table-driven token request vectors and hand-written stall/starvation/saturation/reset cases.
module tb_phy_tx_scheduler;
    import phy_tx_scheduler_pkg::*;

    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              pkt_valid;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_last;
    logic              pkt_ready;
    logic              ack_req;
    logic [1:0]        grtcred_req;
    logic              enc_valid;
    logic              enc_ready;
    comma_sel_t        enc_comma_sel;
    comma_length_sel_t enc_comma_len;
    logic [DATA_W-1:0] enc_data;
    logic              ovf_err;

    phy_tx_scheduler #(.DATA_W(DATA_W), .CNT_W(4), .MAX_CTRL_BURST(4)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pkt_valid     (pkt_valid),
        .pkt_data      (pkt_data),
        .pkt_last      (pkt_last),
        .pkt_ready     (pkt_ready),
        .ack_req       (ack_req),
        .grtcred_req   (grtcred_req),
        .enc_valid     (enc_valid),
        .enc_ready     (enc_ready),
        .enc_comma_sel (enc_comma_sel),
        .enc_comma_len (enc_comma_len),
        .enc_data      (enc_data),
        .ovf_err       (ovf_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        comma_sel_t        sel;
        comma_length_sel_t len;
        logic [31:0]       data;
    } sym_t;

    typedef struct {
        logic       ack;
        logic [1:0] grt;
        int         n;
        comma_sel_t exp [3];
    } vec_t;

    sym_t exp_q[$];
    int   hs_cyc[$];
    sym_t mon_e;
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pkt_ready_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_sym(input comma_sel_t s, input comma_length_sel_t l, input logic [31:0] d);
        sym_t e;
        e.sel  = s;
        e.len  = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_tok(input comma_sel_t s);
        push_sym(s, SELECT_COMMA_1_FLIT, 32'h0);
    endtask

    task automatic push_pkt_word(input logic [31:0] d);
        push_sym(DATA_SEL, SELECT_COMMA_DATA, d);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_vec(input int i, input logic a, input logic [1:0] g, input int n,
                           input comma_sel_t s0, input comma_sel_t s1, input comma_sel_t s2);
        vecs[i].ack    = a;
        vecs[i].grt    = g;
        vecs[i].n      = n;
        vecs[i].exp[0] = s0;
        vecs[i].exp[1] = s1;
        vecs[i].exp[2] = s2;
    endtask

    // Presents one packet word and waits (bounded) until it is consumed.
    task automatic send_word(input logic [31:0] d, input logic last);
        logic got;
        got       = 1'b0;
        pkt_valid = 1'b1;
        pkt_data  = d;
        pkt_last  = last;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = pkt_ready;
            tick();
        end
        check("send_word_consumed", got, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    // Encoder-side monitor: every handshake is compared against the scoreboard head.
    always @(negedge CLK) begin
        cyc++;
        if (nRST) begin
            if (pkt_ready) pkt_ready_cnt++;
            if (enc_valid && enc_ready) begin
                hs_cyc.push_back(cyc);
                check("sb_expected_symbol", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sym_sel", enc_comma_sel, mon_e.sel);
                    check("sym_len", enc_comma_len, mon_e.len);
                    if (mon_e.sel == DATA_SEL) check("sym_data", enc_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pkt_a [3];
        int          pulses;
        logic        got;

        set_vec(0, 1'b1, 2'b00, 1, ACK_SEL,      NADA_SEL,     NADA_SEL);
        set_vec(1, 1'b0, 2'b01, 1, GRTCRED0_SEL, NADA_SEL,     NADA_SEL);
        set_vec(2, 1'b0, 2'b10, 1, GRTCRED1_SEL, NADA_SEL,     NADA_SEL);
        set_vec(3, 1'b1, 2'b11, 3, ACK_SEL,      GRTCRED0_SEL, GRTCRED1_SEL);
        set_vec(4, 1'b0, 2'b11, 2, GRTCRED0_SEL, GRTCRED1_SEL, NADA_SEL);
        set_vec(5, 1'b1, 2'b10, 2, ACK_SEL,      GRTCRED1_SEL, NADA_SEL);

        nRST        = 1'b0;
        pkt_valid   = 1'b0;
        pkt_data    = '0;
        pkt_last    = 1'b0;
        ack_req     = 1'b0;
        grtcred_req = 2'b00;
        enc_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_enc_valid", enc_valid, 1'b0);
        check("rst_pkt_ready", pkt_ready, 1'b0);
        check("rst_comma_sel", enc_comma_sel, NADA_SEL);
        check("rst_comma_len", enc_comma_len, NADA);
        check("rst_enc_data", enc_data, 32'h0);
        check("rst_ovf_err", ovf_err, 1'b0);
        nRST = 1'b1;
        tick();

        // 3-word packet on consecutive handshakes
        enc_ready = 1'b1;
        pkt_a[0] = 32'hA;
        pkt_a[1] = 32'hB;
        pkt_a[2] = 32'hC;
        hs_cyc.delete();
        pkt_ready_cnt = 0;
        push_tok(START_PACKET_SEL);
        for (int i = 0; i < 3; i++) push_pkt_word(pkt_a[i]);
        push_tok(END_PACKET_SEL);
        for (int i = 0; i < 3; i++) send_word(pkt_a[i], i == 2);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        wait_drain("pkt_drain", 20);
        tick();
        check("pkt_ready_cycles", pkt_ready_cnt, 3);
        check("pkt_hs_count", hs_cyc.size(), 5);
        if (hs_cyc.size() == 5) check("pkt_hs_span", hs_cyc[4] - hs_cyc[0], 4);

        // Table-driven token requests: order and one IDLE cycle between tokens
        for (int v = 0; v < 6; v++) begin
            hs_cyc.delete();
            for (int k = 0; k < vecs[v].n; k++) push_tok(vecs[v].exp[k]);
            ack_req     = vecs[v].ack;
            grtcred_req = vecs[v].grt;
            tick();
            ack_req     = 1'b0;
            grtcred_req = 2'b00;
            wait_drain("vec_drain", 20);
            repeat (3) tick();
            check("vec_hs_count", hs_cyc.size(), vecs[v].n);
            for (int k = 1; k < hs_cyc.size(); k++)
                check("vec_token_gap", hs_cyc[k] - hs_cyc[k-1], 2);
        end

        // ACK held off for 5 cycles: outputs stable, counter waits for the handshake
        enc_ready = 1'b0;
        ack_req   = 1'b1;
        tick();
        ack_req = 1'b0;
        got     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            got = enc_valid;
            if (!got) tick();
        end
        check("stall_enc_valid_seen", got, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("stall_enc_valid", enc_valid, 1'b1);
            check("stall_comma_sel", enc_comma_sel, ACK_SEL);
            check("stall_comma_len", enc_comma_len, SELECT_COMMA_1_FLIT);
            check("stall_ack_cnt", dut.ack_cnt, 4'd1);
            @(negedge CLK);
        end
        tick();
        push_tok(ACK_SEL);
        enc_ready = 1'b1;
        @(negedge CLK);
        check("stall_ack_cnt_at_hs", dut.ack_cnt, 4'd1);
        tick();
        check("stall_ack_cnt_after", dut.ack_cnt, 4'd0);
        check("stall_drain", exp_q.size(), 0);
        repeat (2) tick();

        // Starvation guard: packet goes after exactly 4 GRTCRED0 tokens
        grtcred_req = 2'b01;
        tick();
        pulses = 1;
        pkt_valid = 1'b1;
        pkt_data  = 32'h5A5A_0001;
        pkt_last  = 1'b1;
        for (int k = 0; k < 4; k++) push_tok(GRTCRED0_SEL);
        push_tok(START_PACKET_SEL);
        push_pkt_word(32'h5A5A_0001);
        push_tok(END_PACKET_SEL);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = pkt_ready;
            tick();
            pulses++;
        end
        check("starve_pkt_consumed", got, 1'b1);
        grtcred_req = 2'b00;
        pkt_valid   = 1'b0;
        pkt_last    = 1'b0;
        for (int k = 0; k < pulses - 4; k++) push_tok(GRTCRED0_SEL);
        wait_drain("starve_drain", 100);
        repeat (3) tick();
        check("starve_no_ovf", ovf_err, 1'b0);

        // 16 ACK requests with the encoder stalled: saturate at 15, sticky overflow
        enc_ready = 1'b0;
        ack_req   = 1'b1;
        repeat (16) tick();
        ack_req = 1'b0;
        tick();
        check("sat_ack_cnt", dut.ack_cnt, 4'd15);
        check("sat_ovf_err", ovf_err, 1'b1);
        for (int k = 0; k < 15; k++) push_tok(ACK_SEL);
        enc_ready = 1'b1;
        wait_drain("sat_drain", 100);
        repeat (5) tick();
        check("sat_ovf_sticky", ovf_err, 1'b1);
        check("sat_ack_cnt_empty", dut.ack_cnt, 4'd0);

        // Reset in the middle of a 4-word packet
        push_tok(START_PACKET_SEL);
        push_pkt_word(32'h1000_0000);
        push_pkt_word(32'h1000_0001);
        send_word(32'h1000_0000, 1'b0);
        send_word(32'h1000_0001, 1'b0);
        pkt_data = 32'h1000_0002;
        nRST     = 1'b0;
        #1;
        check("mid_rst_state", dut.state, ST_IDLE);
        check("mid_rst_enc_valid", enc_valid, 1'b0);
        check("mid_rst_pkt_ready", pkt_ready, 1'b0);
        check("mid_rst_ack_cnt", dut.ack_cnt, 4'd0);
        check("mid_rst_grt0_cnt", dut.grt0_cnt, 4'd0);
        check("mid_rst_ovf_err", ovf_err, 1'b0);
        check("mid_rst_sb_empty", exp_q.size(), 0);
        pkt_valid = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        push_tok(START_PACKET_SEL);
        push_pkt_word(32'h0000_0077);
        push_tok(END_PACKET_SEL);
        send_word(32'h0000_0077, 1'b1);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        wait_drain("post_rst_drain", 20);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
